// File: rtl/ccd_smooth_3x3.sv
// Streaming 3x3 Gaussian (1-2-1) smoother for 10-bit RGB CCD pixels.
// Two line buffers per channel feed a 3x3 window; fixed 2-clock latency.
module ccd_smooth_3x3 #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned COL_W    = 10
) (
  input  logic       iCCD_PIXCLK,
  input  logic       iRST_N,
  input  logic [9:0] iCCD_R,
  input  logic [9:0] iCCD_G,
  input  logic [9:0] iCCD_B,
  input  logic       iCCD_DVAL,
  input  logic       iCCD_FVAL,
  output logic [9:0] oCCD_R,
  output logic [9:0] oCCD_G,
  output logic [9:0] oCCD_B,
  output logic       oCCD_DVAL
);

  logic             accept;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       row_q, row_d;

  logic [9:0]  pix_in [3];
  logic [9:0]  tap_top [3];
  logic [9:0]  tap_mid [3];
  logic [9:0]  lb0_q [3][H_ACTIVE];
  logic [9:0]  lb1_q [3][H_ACTIVE];
  // Window indexed [channel][row][col]; row 2 / col 2 hold the newest pixel.
  logic [9:0]  win_q [3][3][3];
  logic [13:0] sum [3];

  logic       valid_q;
  logic       border_q;
  logic [9:0] out_q [3];
  logic       dval_q;

  assign accept = iCCD_DVAL & iCCD_FVAL;

  always_comb begin
    pix_in[0] = iCCD_R;
    pix_in[1] = iCCD_G;
    pix_in[2] = iCCD_B;
  end

  // Position counters: column wraps at H_ACTIVE-1, row saturates at 2.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!iCCD_FVAL) begin
      col_d = '0;
      row_d = '0;
    end else if (iCCD_DVAL) begin
      if (col_q == COL_W'(H_ACTIVE - 1)) begin
        col_d = '0;
        if (row_q != 2'd2) row_d = row_q + 2'd1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Taps are read from the pre-edge buffer contents, then overwritten.
  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      tap_top[ch] = lb1_q[ch][col_q];
      tap_mid[ch] = lb0_q[ch][col_q];
    end
  end

  always_ff @(posedge iCCD_PIXCLK) begin
    if (accept) begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        lb1_q[ch][col_q] <= lb0_q[ch][col_q];
        lb0_q[ch][col_q] <= pix_in[ch];
      end
    end
  end

  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned ch = 0; ch < 3; ch++)
        for (int unsigned r = 0; r < 3; r++)
          for (int unsigned c = 0; c < 3; c++)
            win_q[ch][r][c] <= '0;
    end else if (accept) begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_q[ch][r][0] <= win_q[ch][r][1];
          win_q[ch][r][1] <= win_q[ch][r][2];
        end
        win_q[ch][0][2] <= tap_top[ch];
        win_q[ch][1][2] <= tap_mid[ch];
        win_q[ch][2][2] <= pix_in[ch];
      end
    end
  end

  // Border flag captures the pre-increment position of the accepted pixel.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      valid_q  <= 1'b0;
      border_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) border_q <= (row_q < 2'd2) || (col_q < COL_W'(2));
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      logic [13:0] corners;
      logic [13:0] edges;
      corners = 14'(win_q[ch][0][0]) + 14'(win_q[ch][0][2])
              + 14'(win_q[ch][2][0]) + 14'(win_q[ch][2][2]);
      edges   = 14'(win_q[ch][0][1]) + 14'(win_q[ch][1][0])
              + 14'(win_q[ch][1][2]) + 14'(win_q[ch][2][1]);
      sum[ch] = corners + (edges << 1) + (14'(win_q[ch][1][1]) << 2);
    end
  end

  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned ch = 0; ch < 3; ch++) out_q[ch] <= '0;
      dval_q <= 1'b0;
    end else begin
      dval_q <= valid_q;
      if (valid_q) begin
        for (int unsigned ch = 0; ch < 3; ch++)
          out_q[ch] <= border_q ? '0 : sum[ch][13:4];
      end
    end
  end

  assign oCCD_R    = out_q[0];
  assign oCCD_G    = out_q[1];
  assign oCCD_B    = out_q[2];
  assign oCCD_DVAL = dval_q;

endmodule

// File: tb/tb_ccd_smooth_3x3.sv
// Directed bench for ccd_smooth_3x3 (H_ACTIVE=8); expected pixels come from a
// whole-frame reference filter plus hand-computed spot values.
module tb_ccd_smooth_3x3;

  logic       clk;
  logic       rst_n;
  logic [9:0] in_r, in_g, in_b;
  logic       in_dval, in_fval;
  logic [9:0] out_r, out_g, out_b;
  logic       out_dval;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [9:0] img [3][8][8];
  logic       pv;
  logic [9:0] pe [3];
  logic [9:0] last [3];

  ccd_smooth_3x3 #(.H_ACTIVE(8), .COL_W(3)) dut (
    .iCCD_PIXCLK(clk),
    .iRST_N     (rst_n),
    .iCCD_R     (in_r),
    .iCCD_G     (in_g),
    .iCCD_B     (in_b),
    .iCCD_DVAL  (in_dval),
    .iCCD_FVAL  (in_fval),
    .oCCD_R     (out_r),
    .oCCD_G     (out_g),
    .oCCD_B     (out_b),
    .oCCD_DVAL  (out_dval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] filt(input int ch, input int r, input int c);
    int s;
    s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1) * int'(img[ch][r-2+dr][c-2+dc]);
    return 10'(s >> 4);
  endfunction

  // One clock: drive inputs, then check the output due from the previous edge.
  task automatic step(input logic dv, input logic fv, input int r, input int c,
                      input logic [9:0] vr, input logic [9:0] vg, input logic [9:0] vb);
    logic       acc;
    logic [9:0] cur [3];
    in_r = vr; in_g = vg; in_b = vb;
    in_dval = dv; in_fval = fv;
    acc = dv & fv;
    for (int ch = 0; ch < 3; ch++)
      cur[ch] = (acc && r >= 2 && c >= 2) ? filt(ch, r, c) : 10'd0;
    @(posedge clk); #1;
    chk("dval", {9'd0, out_dval}, {9'd0, pv});
    if (pv) for (int ch = 0; ch < 3; ch++) last[ch] = pe[ch];
    chk("r", out_r, last[0]);
    chk("g", out_g, last[1]);
    chk("b", out_b, last[2]);
    pv = acc;
    for (int ch = 0; ch < 3; ch++) pe[ch] = cur[ch];
  endtask

  task automatic pix(input int r, input int c);
    step(1'b1, 1'b1, r, c, img[0][r][c], img[1][r][c], img[2][r][c]);
  endtask

  task automatic gap(input logic fv);
    step(1'b0, fv, 0, 0, 10'd0, 10'd0, 10'd0);
  endtask

  task automatic fill(input logic [9:0] vr, input logic [9:0] vg, input logic [9:0] vb);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        img[0][r][c] = vr; img[1][r][c] = vg; img[2][r][c] = vb;
      end
  endtask

  task automatic run_frame(input int nrows, input bit gaps);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < 8; c++) begin
        pix(r, c);
        if (gaps) gap(1'b1);
      end
    gap(1'b0);
    gap(1'b0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    pv = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin pe[ch] = '0; last[ch] = '0; end
    rst_n = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; in_dval = 1'b0; in_fval = 1'b0;
    #1;
    chk("rst_dval", {9'd0, out_dval}, 10'd0);
    chk("rst_r", out_r, 10'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_g", out_g, 10'd0);
    chk("rst_b", out_b, 10'd0);
    rst_n = 1'b1;
    gap(1'b0);

    // Constant 512, continuous then with alternating DVAL gaps.
    fill(10'd512, 10'd512, 10'd512);
    run_frame(4, 1'b0);
    run_frame(4, 1'b1);

    // Single red impulse at (2,3); hand-computed spot values.
    fill(10'd0, 10'd0, 10'd0);
    img[0][2][3] = 10'd1023;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) begin
        pix(r, c);
        if (r == 3 && c == 5) chk("imp_centre", out_r, 10'd255);
        if (r == 3 && c == 6) chk("imp_edge_h", out_r, 10'd127);
        if (r == 4 && c == 5) chk("imp_edge_v", out_r, 10'd127);
        if (r == 4 && c == 6) chk("imp_corner", out_r, 10'd63);
        if (r == 4 && c == 6) chk("imp_g", out_g, 10'd0);
      end
    gap(1'b0);

    // Horizontal ramp on green, blue held constant.
    fill(10'd0, 10'd0, 10'd300);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[1][r][c] = 10'(16 * c);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++) begin
        pix(r, c);
        if (r == 2 && c >= 4) chk("ramp_g", out_g, 10'(16 * (c - 2)));
      end
    gap(1'b0);
    gap(1'b0);

    // FVAL drops for one clock at col 5 of row 3, then a new frame of 100.
    fill(10'd512, 10'd512, 10'd512);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        if (r < 3 || c < 5) pix(r, c);
    step(1'b1, 1'b0, 0, 0, 10'd512, 10'd512, 10'd512);
    fill(10'd100, 10'd100, 10'd100);
    run_frame(4, 1'b0);

    // Asynchronous reset mid-line, away from any clock edge.
    fill(10'd700, 10'd700, 10'd700);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        if (r < 3 || c < 4) pix(r, c);
    in_dval = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dval", {9'd0, out_dval}, 10'd0);
    chk("arst_r", out_r, 10'd0);
    chk("arst_g", out_g, 10'd0);
    chk("arst_b", out_b, 10'd0);
    @(posedge clk); #1;
    chk("arst_hold", {9'd0, out_dval}, 10'd0);
    #2 rst_n = 1'b1;
    pv = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin pe[ch] = '0; last[ch] = '0; end
    fill(10'd300, 10'd301, 10'd302);
    run_frame(4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
